// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOCKED     = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } arb_state_t;

  // Cycles allowed for the UART to raise tx_busy after a strobe
  localparam logic [2:0] START_TIMEOUT = 3'd4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin owner picker
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic [1:0] pick
);

  // On contention favour the requester that did not own the link last
  always_comb begin
    pick = 2'b00;
    if (valid[0] && valid[1]) begin
      pick = last_owner ? 2'b01 : 2'b10;
    end else if (valid[0]) begin
      pick = 2'b01;
    end else if (valid[1]) begin
      pick = 2'b10;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - arbitrates two byte requesters onto one UART transmitter
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned GAP_MAX   = 8,
  parameter logic [7:0]  EOP_CHAR  = 8'h0A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_busy,
  output logic [1:0] grant,
  output logic       err
);

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
  localparam logic [7:0] GAP_LIM   = 8'(GAP_MAX);

  arb_state_t state;
  logic       last_owner;
  logic [7:0] count;
  logic [7:0] gap;
  logic [2:0] timer;
  logic [1:0] pick;

  logic       owner;
  logic       owner_valid;
  logic [7:0] owner_data;
  logic       accept;
  logic [7:0] count_inc;
  logic [7:0] gap_inc;
  logic       do_release;

  rr_arb2 u_rr_arb2 (
    .valid      ({req1_valid, req0_valid}),
    .last_owner (last_owner),
    .pick       (pick)
  );

  assign owner       = grant[1];
  assign owner_valid = owner ? req1_valid : req0_valid;
  assign owner_data  = owner ? req1_data : req0_data;

  // Only the owner sees ready, and only while the UART is free
  assign req0_ready = (state == LOCKED) & grant[0] & ~tx_busy;
  assign req1_ready = (state == LOCKED) & grant[1] & ~tx_busy;
  assign accept     = owner_valid & (owner ? req1_ready : req0_ready);

  assign count_inc = count + 8'd1;
  assign gap_inc   = gap + 8'd1;

  // Ownership ends on an idle owner, an end-of-packet byte or a full burst
  assign do_release =
      ((state == LOCKED) && !owner_valid && (gap_inc == GAP_LIM)) ||
      ((state == WAIT_DONE) && !tx_busy &&
       ((tx_data == EOP_CHAR) || (count_inc == BURST_LIM)));

  // Arbiter FSM with registered grant, strobe, byte and error outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= 2'b00;
      last_owner <= 1'b1;
      count      <= 8'd0;
      gap        <= 8'd0;
      timer      <= 3'd0;
      tx_data    <= 8'h00;
      tx_wr      <= 1'b0;
      err        <= 1'b0;
    end else begin
      tx_wr <= 1'b0;
      if (do_release) begin
        state      <= IDLE;
        grant      <= 2'b00;
        last_owner <= owner;
        count      <= 8'd0;
        gap        <= 8'd0;
      end else begin
        case (state)
          IDLE: begin
            if (|pick) begin
              grant <= pick;
              gap   <= 8'd0;
              state <= LOCKED;
            end
          end
          LOCKED: begin
            if (accept) begin
              tx_data <= owner_data;
              tx_wr   <= 1'b1;
              timer   <= 3'd0;
              gap     <= 8'd0;
              state   <= WAIT_START;
            end else if (owner_valid) begin
              gap <= 8'd0;
            end else begin
              gap <= gap_inc;
            end
          end
          WAIT_START: begin
            if (tx_busy) begin
              state <= WAIT_DONE;
            end else if (timer == START_TIMEOUT - 3'd1) begin
              err   <= 1'b1;
              state <= WAIT_DONE;
            end else begin
              timer <= timer + 3'd1;
            end
          end
          WAIT_DONE: begin
            if (!tx_busy) begin
              count <= count_inc;
              state <= LOCKED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
